wb_master_bridge: RTL

WB_MASTER_BRIDGE -- requirements
Module: wb_master_bridge

---
 rtl/wb_master_bridge.sv | 87 ++++++++
 1 files changed

// File: rtl/wb_master_bridge.sv
// rtl/wb_master_bridge.sv - CPU request to Wishbone classic single-cycle master bridge with timeout
module wb_master_bridge #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_sel,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        cpu_err,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    output logic [3:0]  m_sel_o,
    output logic        m_we_o,
    output logic        m_stb_o,
    output logic        m_cyc_o,
    input  logic [31:0] m_dat_i,
    input  logic        m_ack_i
);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] wait_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wait_cnt  <= 8'd0;
            m_adr_o   <= 32'd0;
            m_dat_o   <= 32'd0;
            m_sel_o   <= 4'd0;
            m_we_o    <= 1'b0;
            m_stb_o   <= 1'b0;
            m_cyc_o   <= 1'b0;
            cpu_rdata <= 32'd0;
            cpu_ready <= 1'b0;
            cpu_err   <= 1'b0;
        end else begin
            cpu_ready <= 1'b0;
            cpu_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        state    <= BUS;
                        m_adr_o  <= cpu_addr;
                        m_dat_o  <= cpu_wdata;
                        m_sel_o  <= cpu_sel;
                        m_we_o   <= cpu_we;
                        m_stb_o  <= 1'b1;
                        m_cyc_o  <= 1'b1;
                        wait_cnt <= 8'd0;
                    end
                end
                BUS: begin
                    // ACK is tested first so it wins over a timeout on the same edge
                    if (m_ack_i) begin
                        state     <= DONE;
                        m_stb_o   <= 1'b0;
                        m_cyc_o   <= 1'b0;
                        cpu_ready <= 1'b1;
                        if (!m_we_o) cpu_rdata <= m_dat_i;
                    end else if (wait_cnt == LAST_WAIT) begin
                        state     <= DONE;
                        m_stb_o   <= 1'b0;
                        m_cyc_o   <= 1'b0;
                        cpu_ready <= 1'b1;
                        cpu_err   <= 1'b1;
                        if (!m_we_o) cpu_rdata <= ERR_DATA;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
